// File: rtl/sidi_video_out.sv
// Video output stage: two-stage ce_pix pipeline with colour depth conversion,
// ordered dither, blanking and sync polarity normalisation.
module sidi_video_out #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 6,
  parameter int DITHER    = 1,
  parameter int OUT_POL   = 0,
  parameter int POL_CNT_W = 12
) (
  input  logic             CLOCK_27,
  input  logic             RESET_N,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             hblank,
  input  logic             vblank,
  output logic [OUT_W-1:0] VGA_R,
  output logic [OUT_W-1:0] VGA_G,
  output logic [OUT_W-1:0] VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             hs_pol,
  output logic             vs_pol
);

  localparam int   D       = (IN_W > OUT_W) ? IN_W - OUT_W : 0;
  localparam logic OP      = (OUT_POL != 0);
  localparam logic DITH_EN = (DITHER != 0) && (IN_W > OUT_W);

  logic [1:0]                 sync_raw, sync_norm, sync_edge;
  logic [1:0]                 raw_prev_q, raw_prev_d, norm_prev_q, norm_prev_d;
  logic [1:0]                 pol_q, pol_d;
  logic [1:0][POL_CNT_W-1:0]  hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic                       pix_par_q, pix_par_d, line_par_q, line_par_d;
  logic                       frame_par_q, frame_par_d;
  logic [1:0]                 bayer;
  logic [2:0][IN_W-1:0]       s1_rgb_q, s1_rgb_d;
  logic [IN_W-1:0]            s1_off_q, s1_off_d;
  logic                       s1_blank_q, s1_blank_d;
  logic [1:0]                 s1_sync_q, s1_sync_d;
  logic [2:0][OUT_W-1:0]      conv, out_rgb_q, out_rgb_d;
  logic [1:0]                 out_sync_q, out_sync_d;

  always_comb begin
    sync_raw    = {vs_in, hs_in};
    sync_norm   = sync_raw ^ pol_q;
    sync_edge   = sync_norm & ~norm_prev_q;
    raw_prev_d  = sync_raw;
    norm_prev_d = sync_norm;
    pol_d       = pol_q;
    hi_cnt_d    = hi_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    // Polarity is decided on each raw rising edge from the high/low duty seen since the last one
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync_raw[i] && !raw_prev_q[i]) begin
        if (hi_cnt_q[i] != lo_cnt_q[i]) pol_d[i] = (hi_cnt_q[i] > lo_cnt_q[i]);
        hi_cnt_d[i] = '0;
        lo_cnt_d[i] = '0;
      end else if (sync_raw[i]) begin
        if (hi_cnt_q[i] != '1) hi_cnt_d[i] = hi_cnt_q[i] + 1'b1;
      end else if (lo_cnt_q[i] != '1) begin
        lo_cnt_d[i] = lo_cnt_q[i] + 1'b1;
      end
    end

    pix_par_d   = hblank ? 1'b0 : ~pix_par_q;
    line_par_d  = line_par_q ^ sync_edge[0];
    frame_par_d = frame_par_q ^ sync_edge[1];

    case ({line_par_q ^ frame_par_q, pix_par_q})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    s1_off_d   = DITH_EN ? IN_W'(({{IN_W{1'b0}}, bayer} << D) >> 2) : '0;
    s1_rgb_d   = {b_in, g_in, r_in};
    s1_blank_d = hblank | vblank;
    s1_sync_d  = sync_norm;

    out_rgb_d  = s1_blank_q ? '0 : conv;
    out_sync_d = OP ? s1_sync_q : ~s1_sync_q;
  end

  generate
    if (IN_W > OUT_W) begin : g_reduce
      logic [IN_W:0] sum;
      always_comb begin
        sum  = '0;
        conv = '0;
        for (int unsigned c = 0; c < 3; c++) begin
          sum = {1'b0, s1_rgb_q[c]} + {1'b0, s1_off_q};
          if (sum[IN_W]) sum = {1'b0, {IN_W{1'b1}}};
          conv[c] = sum[IN_W-1:D];
        end
      end
    end else begin : g_expand
      // Repeating the input pattern from the MSB down covers equal widths as identity
      always_comb begin
        conv = '0;
        for (int unsigned c = 0; c < 3; c++)
          for (int unsigned i = 0; i < OUT_W; i++)
            conv[c][OUT_W-1-i] = s1_rgb_q[c][IN_W-1-(i % IN_W)];
      end
    end
  endgenerate

  always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
    if (!RESET_N) begin
      raw_prev_q  <= '0;
      norm_prev_q <= '0;
      pol_q       <= '0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      pix_par_q   <= 1'b0;
      line_par_q  <= 1'b0;
      frame_par_q <= 1'b0;
      s1_rgb_q    <= '0;
      s1_off_q    <= '0;
      s1_blank_q  <= 1'b0;
      s1_sync_q   <= '0;
      out_rgb_q   <= '0;
      out_sync_q  <= {2{~OP}};
    end else if (ce_pix) begin
      raw_prev_q  <= raw_prev_d;
      norm_prev_q <= norm_prev_d;
      pol_q       <= pol_d;
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      pix_par_q   <= pix_par_d;
      line_par_q  <= line_par_d;
      frame_par_q <= frame_par_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_off_q    <= s1_off_d;
      s1_blank_q  <= s1_blank_d;
      s1_sync_q   <= s1_sync_d;
      out_rgb_q   <= out_rgb_d;
      out_sync_q  <= out_sync_d;
    end
  end

  assign VGA_R  = out_rgb_q[0];
  assign VGA_G  = out_rgb_q[1];
  assign VGA_B  = out_rgb_q[2];
  assign VGA_HS = out_sync_q[0];
  assign VGA_VS = out_sync_q[1];
  assign hs_pol = pol_q[0];
  assign vs_pol = pol_q[1];

endmodule

// File: tb/tb_sidi_video_out.sv
// Directed bench for sidi_video_out: dither, saturation, blanking, expansion,
// polarity detection and asynchronous reset.
module tb_sidi_video_out;

  logic       CLOCK_27 = 1'b0;
  logic       RESET_N, ce_pix;
  logic [7:0] r_in, g_in, b_in;
  logic [3:0] r4;
  logic       hs_in, vs_in, hblank, vblank;
  logic [5:0] VGA_R, VGA_G, VGA_B, nd_r, nd_g, nd_b, x_r, x_g, x_b;
  logic       VGA_HS, VGA_VS, hs_pol, vs_pol;
  logic       nd_hs, nd_vs, nd_hp, nd_vp, x_hs, x_vs, x_hp, x_vp;

  int unsigned n_tests = 0, n_fail = 0, hs_lows;
  logic [5:0]  q_er, q_nd;
  logic        q_hs, q_vs, q_blank;

  always #5 CLOCK_27 = ~CLOCK_27;

  sidi_video_out #(.IN_W(8), .OUT_W(6), .DITHER(1), .OUT_POL(0), .POL_CNT_W(12)) u_dut (
    .CLOCK_27(CLOCK_27), .RESET_N(RESET_N), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .hs_pol(hs_pol), .vs_pol(vs_pol));

  sidi_video_out #(.IN_W(8), .OUT_W(6), .DITHER(0), .OUT_POL(0), .POL_CNT_W(12)) u_nd (
    .CLOCK_27(CLOCK_27), .RESET_N(RESET_N), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(nd_r), .VGA_G(nd_g), .VGA_B(nd_b),
    .VGA_HS(nd_hs), .VGA_VS(nd_vs), .hs_pol(nd_hp), .vs_pol(nd_vp));

  sidi_video_out #(.IN_W(4), .OUT_W(6), .DITHER(1), .OUT_POL(0), .POL_CNT_W(12)) u_exp (
    .CLOCK_27(CLOCK_27), .RESET_N(RESET_N), .ce_pix(ce_pix),
    .r_in(r4), .g_in(r4), .b_in(r4), .hs_in(hs_in), .vs_in(vs_in),
    .hblank(hblank), .vblank(vblank), .VGA_R(x_r), .VGA_G(x_g), .VGA_B(x_b),
    .VGA_HS(x_hs), .VGA_VS(x_vs), .hs_pol(x_hp), .vs_pol(x_vp));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_27);
    #1;
  endtask

  // Drive one pixel; outputs seen after the edge belong to the pixel driven in the previous call.
  task automatic px(input logic [7:0] r, input logic hb, input logic hs, input logic vs,
                    input logic [5:0] er, input logic [5:0] end_, input logic ehs, input logic evs);
    r_in = r; g_in = r; b_in = r;
    hblank = hb; hs_in = hs; vs_in = vs;
    tick();
    check("R", VGA_R, q_er);
    check("G", VGA_G, q_er);
    check("B", VGA_B, q_er);
    check("ND_R", nd_r, q_nd);
    check("EXP_R", x_r, q_blank ? 6'h00 : 6'h2A);
    check("HS", VGA_HS, q_hs);
    check("VS", VGA_VS, q_vs);
    q_er = er; q_nd = end_; q_hs = ehs; q_vs = evs; q_blank = hb;
  endtask

  task automatic period(input int hi_n, input int lo_n);
    hs_in = 1'b1;
    for (int k = 0; k < hi_n; k++) begin
      tick();
      if (VGA_HS == 1'b0) hs_lows++;
    end
    hs_in = 1'b0;
    for (int k = 0; k < lo_n; k++) begin
      tick();
      if (VGA_HS == 1'b0) hs_lows++;
    end
  endtask

  initial begin
    RESET_N = 1'b1; ce_pix = 1'b0;
    r_in = '0; g_in = '0; b_in = '0; r4 = 4'hA;
    hs_in = 1'b0; vs_in = 1'b0; hblank = 1'b0; vblank = 1'b0;
    #1 RESET_N = 1'b0;
    #20;
    check("RST_R", VGA_R, 6'h00);
    check("RST_HS", VGA_HS, 1'b1);
    check("RST_VS", VGA_VS, 1'b1);
    check("RST_HSPOL", hs_pol, 1'b0);
    tick();
    RESET_N = 1'b1; ce_pix = 1'b1;
    q_er = '0; q_nd = '0; q_hs = 1'b1; q_vs = 1'b1; q_blank = 1'b1;

    // r, hb, hs, vs, expected dither, expected no-dither, HS, VS
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h82, 1, 1, 0, 6'h00, 6'h00, 0, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 1, 0, 1, 6'h00, 6'h00, 1, 0);
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'hFF, 0, 0, 0, 6'h3F, 6'h3F, 1, 1);
    px(8'hFF, 0, 0, 0, 6'h3F, 6'h3F, 1, 1);
    px(8'h00, 0, 0, 0, 6'h00, 6'h00, 1, 1);
    px(8'h00, 0, 0, 0, 6'h00, 6'h00, 1, 1);
    px(8'hFF, 1, 0, 0, 6'h00, 6'h00, 1, 1);
    px(8'hFF, 0, 0, 0, 6'h3F, 6'h3F, 1, 1);
    px(8'h00, 0, 0, 0, 6'h00, 6'h00, 1, 1);
    px(8'h83, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h83, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h83, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h83, 0, 0, 0, 6'h21, 6'h20, 1, 1);

    ce_pix = 1'b0; r_in = 8'hFF; hblank = 1'b1; hs_in = 1'b1;
    repeat (3) tick();
    check("HOLD_R", VGA_R, 6'h20);
    check("HOLD_ND", nd_r, 6'h20);
    check("HOLD_HS", VGA_HS, 1'b1);
    hs_in = 1'b0; hblank = 1'b0; r_in = 8'h00; g_in = 8'h00; b_in = 8'h00; ce_pix = 1'b1;

    period(704, 96);
    check("POL_P1", hs_pol, 1'b0);
    period(704, 96);
    check("POL_P2", hs_pol, 1'b1);
    hs_lows = 0;
    period(704, 96);
    check("HS_LOWS", hs_lows, 96);
    check("POL_P3", hs_pol, 1'b1);
    period(96, 704);
    check("POL_SW_PEND", hs_pol, 1'b1);
    hs_in = 1'b1;
    tick();
    check("POL_SW", hs_pol, 1'b0);
    check("VSPOL", vs_pol, 1'b0);

    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    repeat (3) tick();
    check("PRE_RST_R", VGA_R, 6'h3F);
    check("PRE_RST_HS", VGA_HS, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    check("ARST_R", VGA_R, 6'h00);
    check("ARST_B", VGA_B, 6'h00);
    check("ARST_HS", VGA_HS, 1'b1);
    check("ARST_ND", nd_r, 6'h00);
    hs_in = 1'b0; r_in = 8'h82;
    repeat (2) tick();
    check("ARST_HOLD_R", VGA_R, 6'h00);
    RESET_N = 1'b1;
    q_er = '0; q_nd = '0; q_hs = 1'b1; q_vs = 1'b1; q_blank = 1'b1;
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h21, 6'h20, 1, 1);
    px(8'h82, 0, 0, 0, 6'h20, 6'h20, 1, 1);

    r4 = 4'h5;
    repeat (2) tick();
    check("EXP_5", x_r, 6'h15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sidi_video_out.md
# sidi_video_out

Parametrised video output stage between a guest core's pixel stream and the board VGA pins. It registers RGB and sync on the pixel enable, converts colour depth (ordered 2x2 dither on reduction, MSB replication on expansion), forces black during blanking, and auto-detects input sync polarity so that the board always sees a fixed output polarity. It replaces direct core-to-pin wiring in board tops. The same core can therefore drive boards with 4-, 6- or 8-bit DACs.

## Interface
Parameters:
- IN_W, 8, core colour width per channel (2..10)
- OUT_W, 6, board DAC width per channel (2..10)
- DITHER, 1, enable ordered dither when IN_W > OUT_W
- OUT_POL, 0, output sync polarity: 0 active-low, 1 active-high
- POL_CNT_W, 12, width of sync polarity measurement counters

Ports:
- CLOCK_27  in  1  system clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- ce_pix  in  1  pixel enable; all datapath state advances only when high
- r_in, g_in, b_in  in  IN_W each  core colour
- hs_in, vs_in  in  1  core syncs, polarity unknown
- hblank, vblank  in  1  active-high blanking
- VGA_R, VGA_G, VGA_B  out  OUT_W each  board colour
- VGA_HS, VGA_VS  out  1  board syncs at OUT_POL
- hs_pol, vs_pol  out  1  detected input polarity: 1 = input active-low

## Operation
- Pipeline: two stages, both gated by ce_pix. Stage 1 registers inputs and computes the dither offset. Stage 2 performs add/saturate/truncate, blanking and the sync output mapping.
- Depth reduction (IN_W > OUT_W, D = IN_W-OUT_W):
  - Bayer value b = {0,2,3,1}, indexed by {line_par, pix_par} = 00,01,10,11.
  - Offset = (b << D) >> 2, truncated.
  - With DITHER=0, offset = 0.
  - Sum = in + offset, saturated to 2^IN_W-1. Output = sum[IN_W-1:D].
- Expansion (IN_W < OUT_W): MSB replication to OUT_W bits. Equal widths pass through.
- pix_par: toggles on each ce_pix. Cleared on the ce_pix cycle where hblank is high.
- line_par: toggles on each active-edge of the normalised hsync. XORed with frame_par, which toggles on each normalised vsync active edge.
- Blanking: if hblank|vblank in stage 1, stage-2 RGB = 0. Syncs are unaffected.
- Polarity detection, per sync, independently:
  - Two saturating counters count ce_pix cycles with the input high and with it low.
  - On each rising edge of the raw input (sampled on ce_pix), pol <= (high_cnt > low_cnt), then both counters clear.
  - Equal counts leave pol unchanged.
- Normalisation: norm = in ^ pol (active-high). Output = OUT_POL ? norm : ~norm.
- Polarity change takes effect on the following ce_pix. It is not retroactive on data already in the pipeline.

## Timing
- Latency: 2 ce_pix-qualified cycles from input to all outputs. RGB and syncs stay aligned.
- Outputs hold their value between ce_pix pulses.
- Reset (asynchronous assert, any time including mid-line):
  - VGA_R/G/B = 0.
  - VGA_HS = VGA_VS = ~OUT_POL (inactive).
  - hs_pol = vs_pol = 0.
  - All parity bits, counters and pipeline registers = 0.
- Reset release: first valid output appears 2 ce_pix after release. Polarity becomes valid after one full sync period (second rising edge).
- Counter saturation at 2^POL_CNT_W-1: the comparison still uses saturated values. A sync line stuck constant keeps the last pol.
- ce_pix low for any run: no state changes.

## Test plan
- IN_W=8, OUT_W=6, DITHER=1, constant 0x82, vblank=0:
  - Pixel pairs on an even line -> 0x20, 0x21.
  - Next line -> 0x21, 0x20.
  - Next frame inverts the line phase.
- Input 0xFF every pixel -> 0x3F with no wrap. Input 0x00 -> 0x00.
- IN_W=4, OUT_W=6, input 0xA -> 0x2A. DITHER=0, IN_W=8, input 0x83 -> 0x20 on all pixels.
- hblank high with input 0xFF -> VGA_* = 0 exactly 2 ce_pix later; syncs still pass through.
- Polarity, with ce_pix every cycle:
  - hs_in 96 cycles low / 704 high -> hs_pol=1 after the second rising edge; VGA_HS low for 96 cycles (OUT_POL=0).
  - Switch hs_in to 96 high / 704 low -> hs_pol=0 within one period.
- RESET_N pulsed low mid-line with ce_pix running:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the output resumes 2 ce_pix later with pix_par=0.
